// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame receiver slice.
//   - FSM state encoding used by uart_frame_rx (IDLE, PAYLOAD, CHECK)
//   - default frame start marker
//   - payload length of one frame and the width of its byte index
// ---------------------------------------------------------------------------
package uart_pkg;

    // FSM state encoding, kept as plain constants so older tools and
    // netlist-level tooling see fixed, readable codes.
    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_IDLE    = 2'd0;
    localparam rx_state_t ST_PAYLOAD = 2'd1;
    localparam rx_state_t ST_CHECK   = 2'd2;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Payload bytes per frame (B3, B2, B1, B0) and the index width that
    // addresses them.
    localparam int unsigned FRAME_BYTES = 4;
    localparam int unsigned IDX_W       = 2;

    // Running checksum update: each payload byte folds into the XOR.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_timeout.sv
// ---------------------------------------------------------------------------
// uart_timeout
// Inter-byte idle counter for the frame receiver.
//
// Ports:
//   clk      in   single clock
//   reset    in   asynchronous, active-high reset
//   clear    in   force the count back to zero (has priority over enable)
//   enable   in   advance the count by one this cycle
//   expired  out  high while the count equals TIMEOUT_CYC-1
//
// The count stops at the limit rather than wrapping, so expired stays
// asserted until the owner clears it.
// ---------------------------------------------------------------------------
module uart_timeout
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned TO_W        = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;
    logic            at_limit;

    assign at_limit = (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !at_limit) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = at_limit;

endmodule

// File: rtl/uart_frame_rx.sv
// ---------------------------------------------------------------------------
// uart_frame_rx
// Frame assembler sitting behind a UART byte receiver.
//
// Frame on the byte stream:  SYNC_BYTE, B3, B2, B1, B0, C
// where C = B3 ^ B2 ^ B1 ^ B0 and B3 is the most significant payload byte.
//
// Ports:
//   clk           in   single clock
//   reset         in   asynchronous, active-high reset
//   rx_done_tick  in   one-cycle strobe: rxbus holds a new byte
//   rxbus[7:0]    in   received byte, valid only with rx_done_tick
//   rx_buf[31:0]  out  payload of the last frame whose checksum matched
//   rx_valid      out  one-cycle pulse in the cycle rx_buf is updated
//   frame_err     out  one-cycle pulse when a frame is aborted
//                      (bad checksum or inter-byte timeout)
//
// All outputs are registered; results appear one clock after the strobe of
// the checksum byte. rx_valid and frame_err are mutually exclusive by
// construction (both come from the same CHECK/timeout decision).
// ---------------------------------------------------------------------------
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned TO_W        = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_tick,
    input  logic [7:0]  rxbus,
    output logic [31:0] rx_buf,
    output logic        rx_valid,
    output logic        frame_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    rx_state_t        state_q,     state_d;
    logic [31:0]      shadow_q,    shadow_d;
    logic [7:0]       xor_q,       xor_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [31:0]      rx_buf_q,    rx_buf_d;
    logic             rx_valid_q,  rx_valid_d;
    logic             frame_err_q, frame_err_d;

    // -----------------------------------------------------------------------
    // Inter-byte timeout
    // -----------------------------------------------------------------------
    logic to_clear;
    logic to_enable;
    logic to_expired;

    // Every accepted byte restarts the idle window; sitting in IDLE keeps
    // the counter at zero so a new frame always starts with a full window.
    assign to_clear  = rx_done_tick || (state_q == ST_IDLE);
    assign to_enable = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

    uart_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        xor_d       = xor_q;
        idx_d       = idx_q;
        rx_buf_d    = rx_buf_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Non-sync bytes between frames are line noise, not errors.
                if (rx_done_tick && (rxbus == SYNC_BYTE)) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = '0;
                    xor_d   = '0;
                end
            end

            ST_PAYLOAD: begin
                // A byte in the limit cycle takes precedence over the timeout.
                // SYNC_BYTE values here are ordinary payload.
                if (rx_done_tick) begin
                    shadow_d = {shadow_q[23:0], rxbus};
                    xor_d    = xor_fold(xor_q, rxbus);
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end
                end else if (to_expired) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_CHECK: begin
                if (rx_done_tick) begin
                    if (rxbus == xor_q) begin
                        rx_buf_d   = shadow_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (to_expired) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            xor_q       <= '0;
            idx_q       <= '0;
            rx_buf_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            xor_q       <= xor_d;
            idx_q       <= idx_d;
            rx_buf_q    <= rx_buf_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_buf    = rx_buf_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_rx
// Scoreboard bench for uart_frame_rx. The stimulus process pushes the
// expected outcome of each frame into a queue; the monitor pops one entry
// for every rx_valid / frame_err pulse it observes and compares.
// A short timeout is used so the idle-window cases stay fast.
// ---------------------------------------------------------------------------
module tb_uart_frame_rx;

    localparam int unsigned T    = 16;
    localparam int unsigned TO_W = 5;

    logic        clk;
    logic        reset;
    logic        rx_done_tick;
    logic [7:0]  rxbus;
    logic [31:0] rx_buf;
    logic        rx_valid;
    logic        frame_err;

    typedef struct packed {
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    uart_frame_rx #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (T),
        .TO_W        (TO_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rxbus        (rxbus),
        .rx_buf       (rx_buf),
        .rx_valid     (rx_valid),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: present one byte across the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rxbus        = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rxbus        = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h, required %08h", name, got, want);
        end
    endtask

    task automatic expect_valid(input logic [31:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (rx_valid || frame_err)) begin
                if (rx_valid && frame_err) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL exclusive: got valid=1 err=1, required at most one");
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got valid=%0b err=%0b buf=%08h, required none",
                             rx_valid, frame_err, rx_buf);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (e.is_err) begin
                        if (!frame_err || rx_valid) begin
                            n_bad++;
                            $display("FAIL err_pulse: got valid=%0b err=%0b, required err=1",
                                     rx_valid, frame_err);
                        end
                    end else if (!rx_valid || frame_err || rx_buf !== e.data) begin
                        n_bad++;
                        $display("FAIL valid_pulse: got valid=%0b err=%0b buf=%08h, required valid=1 buf=%08h",
                                 rx_valid, frame_err, rx_buf, e.data);
                    end
                end
            end
        end
    end

    // Watchdog: the stimulus uses fixed cycle counts, this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rxbus        = 8'h00;
        idle(3);
        check32("reset_rx_buf", rx_buf, 32'h0);
        check32("reset_rx_valid", {31'd0, rx_valid}, 32'h0);
        check32("reset_frame_err", {31'd0, frame_err}, 32'h0);
        reset = 1'b0;
        idle(2);

        // Good frame: 12^34^56^78 = 08.
        expect_valid(32'h12345678);
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'h08);
        idle(3);
        check32("good_frame_buf", rx_buf, 32'h12345678);

        // Bad checksum: error, buffer untouched.
        expect_err();
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h56); send_byte(8'h78); send_byte(8'hFF);
        idle(3);
        check32("bad_cksum_hold", rx_buf, 32'h12345678);

        // Leading noise ignored; A5 inside payload is data. A5^00^00^01 = A4.
        expect_valid(32'hA5000001);
        send_byte(8'h00); send_byte(8'h33); send_byte(8'hA5); send_byte(8'hA5);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'hA4);
        idle(3);
        check32("sync_in_payload_buf", rx_buf, 32'hA5000001);

        // Timeout after T idle cycles mid-frame, then a good frame.
        send_byte(8'hA5); send_byte(8'h12);
        expect_err();
        idle(T);
        idle(3);
        check32("timeout_hold", rx_buf, 32'hA5000001);
        // CA^FE^F0^0D = C9.
        expect_valid(32'hCAFEF00D);
        send_byte(8'hA5); send_byte(8'hCA); send_byte(8'hFE);
        send_byte(8'hF0); send_byte(8'h0D); send_byte(8'hC9);
        idle(3);
        check32("after_timeout_buf", rx_buf, 32'hCAFEF00D);

        // Bytes landing in the limit cycle, in PAYLOAD and in CHECK: no timeout.
        expect_valid(32'h12345678);
        send_byte(8'hA5); send_byte(8'h12);
        idle(T - 1);
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        idle(T - 1);
        send_byte(8'h08);
        idle(3);
        check32("limit_cycle_buf", rx_buf, 32'h12345678);

        // Reset mid-frame: partial frame discarded, no activity afterwards.
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
        reset = 1'b1;
        idle(2);
        check32("midframe_reset_buf", rx_buf, 32'h0);
        reset = 1'b0;
        idle(1);
        send_byte(8'h56); send_byte(8'h08);
        idle(T + 4);
        check32("post_reset_buf", rx_buf, 32'h0);

        check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
